// File: rtl/clock_set_ctrl.sv
// Settable 24-hour BCD clock: two debounced buttons drive a RUN/SET_HR/SET_MIN/SET_SEC
// editor, with a blink phase that requests blanking of the digit pair being edited.

module clock_set_ctrl_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_press
);

  localparam logic [7:0] LP_LAST = 8'(DEB_CYCLES - 1);

  logic [1:0] r_sync;
  logic       r_deb;
  logic [7:0] r_cnt;
  logic       r_press;

  // Two-flop synchronizer, stability counter and rising-edge event of the debounced level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_deb   <= 1'b0;
      r_cnt   <= 8'd0;
      r_press <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (r_sync[1] != r_deb) begin
        if (r_cnt == LP_LAST) begin
          r_deb   <= r_sync[1];
          r_cnt   <= 8'd0;
          r_press <= r_sync[1];
        end else begin
          r_cnt   <= r_cnt + 8'd1;
          r_press <= 1'b0;
        end
      end else begin
        r_cnt   <= 8'd0;
        r_press <= 1'b0;
      end
    end
  end

  assign o_press = r_press;

endmodule

module clock_set_ctrl #(
  parameter int DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr1,
  output logic [3:0] hr0,
  output logic [3:0] min1,
  output logic [3:0] min0,
  output logic [3:0] sec1,
  output logic [3:0] sec0,
  output logic [5:0] blank,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_SET_SEC = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_hr;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic       r_blink;
  logic [5:0] r_blank;
  logic       w_mode_ev;
  logic       w_inc_ev;

  // Increment a {tens,ones} BCD pair in the range 00..59, wrapping to 00
  function automatic logic [7:0] inc_base60(input logic [7:0] v);
    logic [7:0] res;
    if (v[3:0] >= 4'd9) begin
      if (v[7:4] >= 4'd5) begin
        res = 8'h00;
      end else begin
        res = {v[7:4] + 4'd1, 4'd0};
      end
    end else begin
      res = {v[7:4], v[3:0] + 4'd1};
    end
    return res;
  endfunction

  function automatic logic [7:0] inc_hours(input logic [7:0] v);
    logic [7:0] res;
    if (v >= 8'h23) begin
      res = 8'h00;
    end else if (v[3:0] >= 4'd9) begin
      res = {v[7:4] + 4'd1, 4'd0};
    end else begin
      res = {v[7:4], v[3:0] + 4'd1};
    end
    return res;
  endfunction

  function automatic logic [5:0] blank_map(input state_t s, input logic b);
    logic [5:0] res;
    case (s)
      ST_SET_HR:  res = {b, b, 4'b0000};
      ST_SET_MIN: res = {2'b00, b, b, 2'b00};
      ST_SET_SEC: res = {4'b0000, b, b};
      default:    res = 6'b000000;
    endcase
    return res;
  endfunction

  clock_set_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_raw   (btn_mode),
    .o_press (w_mode_ev)
  );

  clock_set_ctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_raw   (btn_inc),
    .o_press (w_inc_ev)
  );

  // Mode FSM, time keeping, editing and blink/blank generation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_hr    <= 8'h00;
      r_min   <= 8'h00;
      r_sec   <= 8'h00;
      r_blink <= 1'b0;
      r_blank <= 6'b000000;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (tick) begin
            r_sec <= inc_base60(r_sec);
            if (r_sec == 8'h59) begin
              r_min <= inc_base60(r_min);
              if (r_min == 8'h59) begin
                r_hr <= inc_hours(r_hr);
              end
            end
          end
          if (w_mode_ev) begin
            r_state <= ST_SET_HR;
          end
          r_blink <= 1'b0;
          r_blank <= 6'b000000;
        end
        ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
          // A mode press outranks inc; an accepted inc outranks the blink toggle of a tick
          if (w_mode_ev) begin
            r_state <= (r_state == ST_SET_SEC) ? ST_RUN : state_t'(r_state + 2'd1);
            r_blink <= 1'b0;
            r_blank <= 6'b000000;
          end else if (w_inc_ev) begin
            if (r_state == ST_SET_HR) begin
              r_hr <= inc_hours(r_hr);
            end else if (r_state == ST_SET_MIN) begin
              r_min <= inc_base60(r_min);
            end else begin
              r_sec <= inc_base60(r_sec);
            end
            r_blink <= 1'b0;
            r_blank <= 6'b000000;
          end else if (tick) begin
            r_blink <= ~r_blink;
            r_blank <= blank_map(r_state, ~r_blink);
          end else begin
            r_blank <= blank_map(r_state, r_blink);
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_blink <= 1'b0;
          r_blank <= 6'b000000;
        end
      endcase
    end
  end

  assign hr1   = r_hr[7:4];
  assign hr0   = r_hr[3:0];
  assign min1  = r_min[7:4];
  assign min0  = r_min[3:0];
  assign sec1  = r_sec[7:4];
  assign sec0  = r_sec[3:0];
  assign blank = r_blank;
  assign mode  = r_state;

endmodule
